// File: rtl/pulpemu_ctrl_pkg.sv
// rtl/pulpemu_ctrl_pkg.sv - run-control states, ctrl bit indices and status layout
package pulpemu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_READY   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam int REL_BIT   = 31;
  localparam int FETCH_BIT = 0;

  localparam int STAT_EOC       = 0;
  localparam int STAT_RET_LSB   = 1;
  localparam int STAT_RUN       = 3;
  localparam int STAT_TMO       = 4;
  localparam int STAT_STATE_LSB = 5;
  localparam int STAT_CNT_LSB   = 8;

  localparam logic [23:0] CNT_MAX = 24'hFFFFFF;

endpackage

// File: rtl/pulpemu_debounce.sv
// rtl/pulpemu_debounce.sv - single-bit filter, follows the input after DEB_CYCLES differing samples
module pulpemu_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pulpemu_ctrl.sv
// rtl/pulpemu_ctrl.sv - PS-driven run-control sequencer for the PULPino core
module pulpemu_ctrl
  import pulpemu_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int RST_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_i,
  input  logic        eoc_i,
  input  logic [1:0]  return_i,
  input  logic        core_rstn_i,
  output logic        core_rst_no,
  output logic        fetch_en_o,
  output logic [31:0] status_o
);

  localparam logic [15:0] TMO_LAST = 16'(RST_TIMEOUT - 1);

  state_t      state;
  logic        rel_f, fetch_f;
  logic [1:0]  eoc_q, rstn_q;
  logic        eoc_s, rstn_s;
  logic [23:0] cyc_cnt;
  logic [15:0] tmo_cnt;
  logic        eoc_flag, tmo_flag;
  logic [1:0]  ret_q;
  logic        ctrl_unused;

  assign ctrl_unused = ^ctrl_i[30:1];

  pulpemu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rel (
    .clk(clk), .rst(rst), .din(ctrl_i[REL_BIT]), .dout(rel_f)
  );

  pulpemu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fetch (
    .clk(clk), .rst(rst), .din(ctrl_i[FETCH_BIT]), .dout(fetch_f)
  );

  // Core-domain signals cross in through plain 2-flop synchronizers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_q  <= '0;
      rstn_q <= '0;
    end else begin
      eoc_q  <= {eoc_q[0], eoc_i};
      rstn_q <= {rstn_q[0], core_rstn_i};
    end
  end

  assign eoc_s  = eoc_q[1];
  assign rstn_s = rstn_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      core_rst_no <= 1'b0;
      fetch_en_o  <= 1'b0;
      cyc_cnt     <= '0;
      tmo_cnt     <= '0;
      eoc_flag    <= 1'b0;
      tmo_flag    <= 1'b0;
      ret_q       <= '0;
    end else if (state != ST_IDLE && !rel_f) begin
      // Dropping release overrides everything else; status is left intact.
      state       <= ST_IDLE;
      core_rst_no <= 1'b0;
      fetch_en_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rel_f) begin
            state       <= ST_RELEASE;
            core_rst_no <= 1'b1;
            cyc_cnt     <= '0;
            tmo_cnt     <= '0;
            eoc_flag    <= 1'b0;
            tmo_flag    <= 1'b0;
            ret_q       <= '0;
          end
        end
        ST_RELEASE: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (rstn_s) begin
            state <= ST_READY;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= ST_ERROR;
            tmo_flag    <= 1'b1;
            core_rst_no <= 1'b0;
          end
        end
        ST_READY: begin
          if (fetch_f) begin
            state      <= ST_RUN;
            fetch_en_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (eoc_s) begin
            state      <= ST_DONE;
            fetch_en_o <= 1'b0;
            eoc_flag   <= 1'b1;
            ret_q      <= return_i;
          end else if (!rstn_s) begin
            state       <= ST_ERROR;
            fetch_en_o  <= 1'b0;
            core_rst_no <= 1'b0;
          end else if (cyc_cnt != CNT_MAX) begin
            cyc_cnt <= cyc_cnt + 24'd1;
          end
        end
        ST_DONE, ST_ERROR: ;
        default: begin
          state       <= ST_IDLE;
          core_rst_no <= 1'b0;
          fetch_en_o  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status_o = '0;
    status_o[STAT_EOC]               = eoc_flag;
    status_o[STAT_RET_LSB +: 2]      = ret_q;
    status_o[STAT_RUN]               = (state == ST_RUN);
    status_o[STAT_TMO]               = tmo_flag;
    status_o[STAT_STATE_LSB +: 3]    = state;
    status_o[STAT_CNT_LSB +: 24]     = cyc_cnt;
  end

endmodule

// File: tb/tb_pulpemu_ctrl.sv
// tb/tb_pulpemu_ctrl.sv - directed bench for pulpemu_ctrl with DEB_CYCLES=4, RST_TIMEOUT=8
module tb_pulpemu_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_i;
  logic        eoc_i;
  logic [1:0]  return_i;
  logic        core_rstn_i;
  logic        core_rst_no;
  logic        fetch_en_o;
  logic [31:0] status_o;

  int total = 0;
  int bad   = 0;

  pulpemu_ctrl #(.DEB_CYCLES(4), .RST_TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_i(ctrl_i),
    .eoc_i(eoc_i),
    .return_i(return_i),
    .core_rstn_i(core_rstn_i),
    .core_rst_no(core_rst_no),
    .fetch_en_o(fetch_en_o),
    .status_o(status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    ctrl_i      = 32'h0;
    eoc_i       = 1'b0;
    return_i    = 2'd0;
    core_rstn_i = 1'b0;
    tick(2);
    chk("reset_rstno",  {31'd0, core_rst_no}, 32'd0);
    chk("reset_fetch",  {31'd0, fetch_en_o},  32'd0);
    chk("reset_status", status_o,             32'd0);
    rst = 1'b0;
    tick(2);

    // 3-cycle glitch on release is rejected
    ctrl_i = 32'h8000_0000;
    tick(3);
    ctrl_i = 32'h0;
    tick(6);
    chk("glitch3_rstno",  {31'd0, core_rst_no}, 32'd0);
    chk("glitch3_status", status_o,             32'd0);

    // 4-cycle pulse: release seen on the 5th edge, then falls back
    ctrl_i = 32'h8000_0000;
    tick(4);
    ctrl_i = 32'h0;
    chk("pulse4_edge4_rstno", {31'd0, core_rst_no}, 32'd0);
    tick(1);
    chk("pulse4_edge5_rstno", {31'd0, core_rst_no}, 32'd1);
    chk("pulse4_edge5_state", status_o,             32'h0000_0020);
    tick(4);
    chk("pulse4_back_idle",   status_o,             32'd0);
    chk("pulse4_back_rstno",  {31'd0, core_rst_no}, 32'd0);
    tick(3);

    // Release timeout with core reset never deasserting
    ctrl_i = 32'h8000_0000;
    tick(12);
    chk("tmo_still_release", status_o, 32'h0000_0020);
    tick(1);
    chk("tmo_error_status", status_o,             32'h0000_00B0);
    chk("tmo_error_rstno",  {31'd0, core_rst_no}, 32'd0);
    tick(3);
    chk("tmo_error_hold",   status_o,             32'h0000_00B0);
    ctrl_i = 32'h0;
    tick(5);
    chk("tmo_idle_retained", status_o, 32'h0000_0010);
    tick(2);

    // Normal run of 100 RUN cycles ending with return code 2
    ctrl_i = 32'h8000_0000;
    tick(5);
    core_rstn_i = 1'b1;
    tick(3);
    chk("run_ready", status_o, 32'h0000_0040);
    ctrl_i = 32'h8000_0001;
    tick(5);
    chk("run_enter",       status_o,            32'h0000_0068);
    chk("run_enter_fetch", {31'd0, fetch_en_o}, 32'd1);
    tick(20);
    ctrl_i = 32'h8000_0000;
    tick(78);
    eoc_i    = 1'b1;
    return_i = 2'd2;
    tick(2);
    chk("run_before_done", status_o, 32'h0000_6468);
    tick(1);
    chk("run_done",        status_o,            32'h0000_6485);
    chk("run_done_fetch",  {31'd0, fetch_en_o}, 32'd0);
    chk("run_done_rstno",  {31'd0, core_rst_no}, 32'd1);
    tick(5);
    chk("run_done_frozen", status_o, 32'h0000_6485);
    ctrl_i      = 32'h0;
    eoc_i       = 1'b0;
    return_i    = 2'd0;
    core_rstn_i = 1'b0;
    tick(5);
    chk("run_idle_retained", status_o,             32'h0000_6405);
    chk("run_idle_rstno",    {31'd0, core_rst_no}, 32'd0);
    tick(2);

    // Release drop and synced eoc arrive together: release wins
    ctrl_i      = 32'h8000_0001;
    core_rstn_i = 1'b1;
    tick(7);
    chk("prio_run", status_o, 32'h0000_0068);
    tick(10);
    ctrl_i = 32'h0;
    tick(2);
    eoc_i    = 1'b1;
    return_i = 2'd3;
    tick(2);
    chk("prio_pre", status_o, 32'h0000_0E68);
    tick(1);
    chk("prio_idle",  status_o,            32'h0000_0E00);
    chk("prio_fetch", {31'd0, fetch_en_o}, 32'd0);
    eoc_i    = 1'b0;
    return_i = 2'd0;
    tick(2);

    // Counter saturation from a preloaded value
    ctrl_i = 32'h8000_0001;
    tick(7);
    chk("sat_run", status_o, 32'h0000_0068);
    force dut.cyc_cnt = 24'hFFFFFD;
    #1;
    release dut.cyc_cnt;
    tick(1);
    chk("sat_fffffe", status_o, 32'hFFFF_FE68);
    tick(1);
    chk("sat_ffffff", status_o, 32'hFFFF_FF68);
    tick(3);
    chk("sat_hold",   status_o, 32'hFFFF_FF68);

    // Asynchronous reset in RUN clears outputs without a clock edge
    chk("areset_pre_fetch", {31'd0, fetch_en_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("areset_rstno",  {31'd0, core_rst_no}, 32'd0);
    chk("areset_fetch",  {31'd0, fetch_en_o},  32'd0);
    chk("areset_status", status_o,             32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulpemu_ctrl.md
# pulpemu_ctrl

Run-control sequencer between the Zynq PS control/status registers and the PULPino core on the emulator top. It debounces the PS control word, sequences core reset release and fetch enable, and captures end-of-computation and return code from the core clock domain. It publishes a 32-bit status word with a saturating run-cycle counter back to the PS. Its outputs drive the clock/reset generator reset input and the core fetch-enable input directly.

## Interface
Parameters:
- DEB_CYCLES, 16: consecutive stable samples needed before a control bit is accepted. Legal range 1..255.
- RST_TIMEOUT, 1024: cycles allowed in RELEASE for the synchronized core reset to deassert. Legal range 1..65535.

Ports:
- clk  in  1  PS fabric clock.
- rst  in  1  Asynchronous, active-high reset.
- ctrl_i  in  32  PS control word. Bit 31 requests core reset release; bit 0 requests fetch. Other bits are ignored.
- eoc_i  in  1  End of computation, from the core clock domain.
- return_i  in  2  Core return code. Quasi-static while eoc_i is high.
- core_rstn_i  in  1  Synchronized core reset from the clock generator, core domain.
- core_rst_no  out  1  Drives the clock generator rst_ni; 0 holds the core in reset.
- fetch_en_o  out  1  Core fetch enable.
- status_o  out  32  Status word (layout under Operation).

## Operation
- eoc_i and core_rstn_i pass through 2-flop synchronizers with reset value 0. return_i is sampled only when the synchronized eoc is 1.
- Debounce ctrl_i[31] and ctrl_i[0] independently:
  - The filtered value changes only after the raw bit differs from it on DEB_CYCLES consecutive edges.
  - Any agreeing sample resets that bit's counter.
  - Filtered values reset to 0.
- FSM states and encodings: IDLE=0, RELEASE=1, READY=2, RUN=3, DONE=4, ERROR=5.
  - IDLE: core_rst_no=0, fetch_en_o=0. On filtered rel=1, go to RELEASE; clear the counter, sticky eoc, return and timeout.
  - RELEASE: core_rst_no=1. Timeout counter increments each cycle. Synced core_rstn=1 goes to READY. Counter reaching RST_TIMEOUT goes to ERROR and sets the timeout bit.
  - READY: core_rst_no=1. Filtered fetch=1 goes to RUN.
  - RUN: fetch_en_o=1. Cycle counter increments and saturates at 0xFFFFFF. Synced eoc=1 goes to DONE; capture return and set sticky eoc. Synced core_rstn=0 goes to ERROR.
  - DONE: fetch_en_o=0, counter frozen, core_rst_no=1.
  - ERROR: core_rst_no=0, fetch_en_o=0. Hold until rel drops.
- From every state except IDLE, filtered rel=0 goes to IDLE. This has highest priority and wins over simultaneous eoc, timeout or core reset loss.
- Status is retained in IDLE so the PS can read it after release is dropped.
- Filtered fetch=0 in RUN does not stop the run.
- status_o layout:
  - [0] sticky eoc
  - [2:1] return code
  - [3] running (state==RUN)
  - [4] timeout
  - [7:5] state
  - [31:8] cycle count
- Reset values: core_rst_no=0, fetch_en_o=0, status_o=0, state=IDLE, all counters 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- ctrl_i edge to filtered change: DEB_CYCLES edges. FSM transition takes one more edge, and the output updates on that same edge.
- Core-domain input to FSM reaction: 2 edges of synchronizer plus 1 edge of transition.
- The cycle counter counts RUN cycles exactly: it equals the number of edges with state==RUN, excluding the edge that exits RUN.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Outputs go to reset values without waiting for a clock.
- The timeout counter is 16 bits wide and clears on every entry to RELEASE.

## Structure
- pulpemu_ctrl_pkg holds:
  - the state enum (3 bits)
  - status bit-position constants
  - ctrl bit indices (REL_BIT=31, FETCH_BIT=0)
- Natural sub-module: pulpemu_debounce, a single-bit filter with a DEB_CYCLES parameter, instantiated twice.
- Synchronizers stay inline.

## Test plan
All scenarios use DEB_CYCLES=4 and RST_TIMEOUT=8.
- Normal run:
  - Stimulus: ctrl_i=0x80000000; core_rstn_i high 3 cycles later; ctrl_i=0x80000001; eoc_i with return_i=2 after 100 RUN cycles.
  - Response: status_o[7:0]=0x85, count=100 (±2 sync), fetch_en_o=0.
- Glitch rejection: 3-cycle pulse on ctrl_i[31] leaves core_rst_no=0 and state IDLE. A 4-cycle pulse gives core_rst_no=1 on the 5th edge.
- Release timeout: rel=1 with core_rstn_i held 0 gives state ERROR, status[4]=1 and core_rst_no=0 after 8 RELEASE cycles.
- Priority: drop ctrl_i[31] so filtered rel falls on the same edge that synced eoc rises. Response: state IDLE, status[0]=0, counter retained.
- Saturation: force a long RUN (or preload the counter in the bench). The counter stays at 0xFFFFFF with no wrap.
- Async reset asserted in RUN: core_rst_no, fetch_en_o and status_o all go to 0 before the next clk edge.
